// File: rtl/riscv_decode_pkg.sv
// Shared decode definitions for the RV32I ALU decode stage: opcode and
// funct7 constants, ALU operation codes and the decoded-entry record.
package riscv_decode_pkg;

   localparam int DEC_XLEN = 32;

   localparam logic [6:0] OP_REG  = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [4:0] {
      ALU_NONE = 5'd0,
      ALU_ADD  = 5'd1,
      ALU_SUB  = 5'd2,
      ALU_XOR  = 5'd3,
      ALU_OR   = 5'd4,
      ALU_AND  = 5'd5,
      ALU_SLL  = 5'd6,
      ALU_SRL  = 5'd7,
      ALU_SRA  = 5'd8,
      ALU_SLT  = 5'd9,
      ALU_SLTU = 5'd10
   } alu_ctrl_e;

   typedef struct packed {
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [DEC_XLEN-1:0] imm;
      logic                use_imm;
      alu_ctrl_e           alu_ctrl;
      logic                illegal;
   } decoded_t;

   function automatic logic [DEC_XLEN-1:0] sext12(input logic [11:0] v);
      return {{(DEC_XLEN-12){v[11]}}, v};
   endfunction

endpackage

// File: rtl/decode_alu_comb.sv
// Pure combinational RV32I ALU-instruction decoder (R-type and I-type).
// Unsupported encodings still report their register fields but carry
// illegal=1 and a zero operation code.
module decode_alu_comb
   import riscv_decode_pkg::*;
(
   input  logic [31:0] i_instr,
   output decoded_t    o_dec
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];

   // Field extraction and operation lookup; illegal unless a legal case clears it
   always_comb begin
      o_dec          = '0;
      o_dec.alu_ctrl = ALU_NONE;
      o_dec.illegal  = 1'b1;
      o_dec.rs1      = i_instr[19:15];
      o_dec.rd       = i_instr[11:7];
      case (w_opcode)
         OP_REG: begin
            o_dec.rs2 = i_instr[24:20];
            case (w_funct7)
               F7_BASE: begin
                  o_dec.illegal = 1'b0;
                  case (w_funct3)
                     3'b000:  o_dec.alu_ctrl = ALU_ADD;
                     3'b001:  o_dec.alu_ctrl = ALU_SLL;
                     3'b010:  o_dec.alu_ctrl = ALU_SLT;
                     3'b011:  o_dec.alu_ctrl = ALU_SLTU;
                     3'b100:  o_dec.alu_ctrl = ALU_XOR;
                     3'b101:  o_dec.alu_ctrl = ALU_SRL;
                     3'b110:  o_dec.alu_ctrl = ALU_OR;
                     default: o_dec.alu_ctrl = ALU_AND;
                  endcase
               end
               F7_ALT: begin
                  case (w_funct3)
                     3'b000: begin
                        o_dec.alu_ctrl = ALU_SUB;
                        o_dec.illegal  = 1'b0;
                     end
                     3'b101: begin
                        o_dec.alu_ctrl = ALU_SRA;
                        o_dec.illegal  = 1'b0;
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
         OP_IMM: begin
            // Immediate carries the shift-amount bits too; consumers mask as needed
            o_dec.imm     = sext12(i_instr[31:20]);
            o_dec.use_imm = 1'b1;
            case (w_funct3)
               3'b000: begin o_dec.alu_ctrl = ALU_ADD;  o_dec.illegal = 1'b0; end
               3'b010: begin o_dec.alu_ctrl = ALU_SLT;  o_dec.illegal = 1'b0; end
               3'b011: begin o_dec.alu_ctrl = ALU_SLTU; o_dec.illegal = 1'b0; end
               3'b100: begin o_dec.alu_ctrl = ALU_XOR;  o_dec.illegal = 1'b0; end
               3'b110: begin o_dec.alu_ctrl = ALU_OR;   o_dec.illegal = 1'b0; end
               3'b111: begin o_dec.alu_ctrl = ALU_AND;  o_dec.illegal = 1'b0; end
               3'b001: begin
                  if (w_funct7 == F7_BASE) begin
                     o_dec.alu_ctrl = ALU_SLL;
                     o_dec.illegal  = 1'b0;
                  end
               end
               default: begin
                  if (w_funct7 == F7_BASE) begin
                     o_dec.alu_ctrl = ALU_SRL;
                     o_dec.illegal  = 1'b0;
                  end else if (w_funct7 == F7_ALT) begin
                     o_dec.alu_ctrl = ALU_SRA;
                     o_dec.illegal  = 1'b0;
                  end
               end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_alu_stage.sv
// Registered decode stage: one main entry feeding the outputs plus one skid
// entry so in_ready can come straight from a flop without losing throughput.
// Flush empties both entries and drops the same-cycle input. Accepted illegal
// instructions are counted with saturation.
module decode_alu_stage
   import riscv_decode_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ALU_CTRL_W = 5,
   parameter int ILL_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_instr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4:0]            out_rs1,
   output logic [4:0]            out_rs2,
   output logic [4:0]            out_rd,
   output logic [XLEN-1:0]       out_imm,
   output logic                  out_use_imm,
   output logic [ALU_CTRL_W-1:0] out_alu_control,
   output logic                  out_illegal,
   output logic [ILL_CNT_W-1:0]  illegal_count
);

   localparam logic [ILL_CNT_W-1:0] ILL_MAX = '1;

   decoded_t               w_dec;
   decoded_t               r_main;
   decoded_t               r_skid;
   logic                   r_main_valid;
   logic                   r_skid_valid;
   logic                   r_in_ready;
   logic [ILL_CNT_W-1:0]   r_ill_cnt;

   decoded_t               w_main_nxt;
   decoded_t               w_skid_nxt;
   logic                   w_main_valid_nxt;
   logic                   w_skid_valid_nxt;
   logic                   w_accept;
   logic                   w_drain;

   decode_alu_comb u_decode (
      .i_instr (in_instr[31:0]),
      .o_dec   (w_dec)
   );

   assign w_accept = in_valid && r_in_ready && !flush;
   assign w_drain  = r_main_valid && out_ready;

   // Main/skid next state: skid always refills main before new input so order is kept
   always_comb begin
      w_main_nxt       = r_main;
      w_skid_nxt       = r_skid;
      w_main_valid_nxt = r_main_valid;
      w_skid_valid_nxt = r_skid_valid;
      if (flush) begin
         w_main_valid_nxt = 1'b0;
         w_skid_valid_nxt = 1'b0;
      end else if (!r_main_valid || w_drain) begin
         if (r_skid_valid) begin
            w_main_nxt       = r_skid;
            w_main_valid_nxt = 1'b1;
            w_skid_valid_nxt = 1'b0;
         end else if (w_accept) begin
            w_main_nxt       = w_dec;
            w_main_valid_nxt = 1'b1;
         end else begin
            w_main_valid_nxt = 1'b0;
         end
      end else if (w_accept) begin
         w_skid_nxt       = w_dec;
         w_skid_valid_nxt = 1'b1;
      end
   end

   // Entry registers and the registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         r_main       <= w_main_nxt;
         r_skid       <= w_skid_nxt;
         r_main_valid <= w_main_valid_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_in_ready   <= !w_skid_valid_nxt;
      end
   end

   // Saturating count of accepted illegal instructions; flushed inputs never count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ill_cnt <= '0;
      end else if (w_accept && w_dec.illegal && (r_ill_cnt != ILL_MAX)) begin
         r_ill_cnt <= r_ill_cnt + 1'b1;
      end
   end

   assign in_ready        = r_in_ready;
   assign out_valid       = r_main_valid;
   assign out_rs1         = r_main.rs1;
   assign out_rs2         = r_main.rs2;
   assign out_rd          = r_main.rd;
   assign out_imm         = XLEN'(r_main.imm);
   assign out_use_imm     = r_main.use_imm;
   assign out_alu_control = ALU_CTRL_W'(r_main.alu_ctrl);
   assign out_illegal     = r_main.illegal;
   assign illegal_count   = r_ill_cnt;

endmodule

// File: tb/tb_decode_alu_stage.sv
// Directed bench for decode_alu_stage: decode vectors, skid/stall streaming,
// flush and counter saturation with mid-stream reset.
module tb_decode_alu_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [31:0] out_imm;
   logic        out_use_imm;
   logic [4:0]  out_alu_control;
   logic        out_illegal;
   logic [7:0]  illegal_count;

   int n_pass  = 0;
   int n_total = 0;
   int exp_cnt = 0;

   localparam logic [31:0] MUL_INSTR = 32'h022081B3;

   typedef struct packed {
      logic [31:0] instr;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic [4:0]  alu;
      logic        ill;
   } vec_t;

   decode_alu_stage #(.XLEN(32), .ALU_CTRL_W(5), .ILL_CNT_W(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instr        (in_instr),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_rs1         (out_rs1),
      .out_rs2         (out_rs2),
      .out_rd          (out_rd),
      .out_imm         (out_imm),
      .out_use_imm     (out_use_imm),
      .out_alu_control (out_alu_control),
      .out_illegal     (out_illegal),
      .illegal_count   (illegal_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] addi_tag(input int k);
      return {12'(k), 5'd0, 3'b000, 5'(k + 1), 7'b0010011};
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      out_ready = 1'b1;
      step();
      step();
      rst_n   = 1'b1;
      exp_cnt = 0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
      else n_pass++;
      n_total++;
      if ({out_rs1, out_rs2, out_rd, out_imm, out_use_imm, out_alu_control, out_illegal} !== '0)
         $display("FAIL reset_fields: rs1=%0d rs2=%0d rd=%0d imm=%h alu=%0d want all 0",
                  out_rs1, out_rs2, out_rd, out_imm, out_alu_control);
      else n_pass++;
      n_total++;
      if (illegal_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", illegal_count);
      else n_pass++;
   endtask

   task automatic test_decode();
      vec_t vecs [8];
      vecs[0] = '{32'h002081B3, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 5'd1,  1'b0}; // add
      vecs[1] = '{32'h407302B3, 5'd6, 5'd7, 5'd5, 32'h0,        1'b0, 5'd2,  1'b0}; // sub
      vecs[2] = '{32'h40325213, 5'd4, 5'd0, 5'd4, 32'h403,      1'b1, 5'd8,  1'b0}; // srai
      vecs[3] = '{32'hFFF00093, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 5'd1,  1'b0}; // addi -1
      vecs[4] = '{MUL_INSTR,    5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 5'd0,  1'b1}; // mul
      vecs[5] = '{32'h00C5B533, 5'd11, 5'd12, 5'd10, 32'h0,     1'b0, 5'd10, 1'b0}; // sltu
      vecs[6] = '{32'h40101093, 5'd0, 5'd0, 5'd1, 32'h401,      1'b1, 5'd0,  1'b1}; // slli bad f7
      vecs[7] = '{32'h000010B7, 5'd0, 5'd0, 5'd1, 32'h0,        1'b0, 5'd0,  1'b1}; // lui
      for (int i = 0; i < 8; i++) begin
         in_valid  = 1'b1;
         in_instr  = vecs[i].instr;
         out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         if (vecs[i].ill) exp_cnt++;
         n_total++;
         if (out_valid !== 1'b1) $display("FAIL decode%0d_valid: got %b want 1", i, out_valid);
         else n_pass++;
         n_total++;
         if ({out_rs1, out_rs2, out_rd, out_imm, out_use_imm, out_alu_control, out_illegal} !==
             {vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm, vecs[i].use_imm, vecs[i].alu, vecs[i].ill})
            $display("FAIL decode%0d_fields: got rs1=%0d rs2=%0d rd=%0d imm=%h ui=%b alu=%0d ill=%b want rs1=%0d rs2=%0d rd=%0d imm=%h ui=%b alu=%0d ill=%b",
                     i, out_rs1, out_rs2, out_rd, out_imm, out_use_imm, out_alu_control, out_illegal,
                     vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm, vecs[i].use_imm, vecs[i].alu, vecs[i].ill);
         else n_pass++;
         n_total++;
         if (illegal_count !== 8'(exp_cnt))
            $display("FAIL decode%0d_count: got %0d want %0d", i, illegal_count, exp_cnt);
         else n_pass++;
         step();
      end
   endtask

   // Four tagged addi instructions; stall_mask bit c forces out_ready low in cycle c
   task automatic run_stream(input string name, input logic [7:0] stall_mask,
                             input int exp_last, input int chk_cycle, input logic exp_rdy);
      int sent = 0;
      int got  = 0;
      int last = -1;
      for (int c = 0; c < 20 && got < 4; c++) begin
         in_valid  = (sent < 4);
         in_instr  = addi_tag(sent);
         out_ready = (c < 8) ? !stall_mask[c] : 1'b1;
         if (c == chk_cycle) begin
            n_total++;
            if (in_ready !== exp_rdy)
               $display("FAIL %s_in_ready_c%0d: got %b want %b", name, c, in_ready, exp_rdy);
            else n_pass++;
         end
         if (out_valid && out_ready) begin
            n_total++;
            if (out_rd !== 5'(got + 1))
               $display("FAIL %s_order: got rd=%0d want rd=%0d", name, out_rd, got + 1);
            else n_pass++;
            got++;
            last = c;
         end
         if (in_valid && in_ready) sent++;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_total++;
      if (got != 4) $display("FAIL %s_count: got %0d outputs want 4", name, got);
      else n_pass++;
      n_total++;
      if (last != exp_last) $display("FAIL %s_last_cycle: got %0d want %0d", name, last, exp_last);
      else n_pass++;
      step();
      step();
   endtask

   task automatic test_back_to_back();
      run_stream("stream_cont",  8'b0000_0000, 4, 2, 1'b1);
      run_stream("stream_stall", 8'b0001_1100, 7, 3, 1'b0);
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = addi_tag(0);
      step();
      in_instr = addi_tag(1);
      step();
      n_total++;
      if ({out_valid, in_ready} !== 2'b10)
         $display("FAIL flush_prefill: got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready);
      else n_pass++;
      flush    = 1'b1;
      in_instr = MUL_INSTR;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      n_total++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL flush_full: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
      else n_pass++;
      // Main held, skid empty: same-cycle illegal input must be dropped uncounted
      in_valid = 1'b1;
      in_instr = addi_tag(2);
      step();
      flush    = 1'b1;
      in_instr = MUL_INSTR;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      n_total++;
      if (illegal_count !== 8'(exp_cnt))
         $display("FAIL flush_count: got %0d want %0d", illegal_count, exp_cnt);
      else n_pass++;
      out_ready = 1'b1;
      step();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL flush_dropped: got valid=%b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_saturate();
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = MUL_INSTR;
      repeat (254) step();
      n_total++;
      if (illegal_count !== 8'd254) $display("FAIL sat_254: got %0d want 254", illegal_count);
      else n_pass++;
      repeat (50) step();
      n_total++;
      if (illegal_count !== 8'd255) $display("FAIL sat_255: got %0d want 255", illegal_count);
      else n_pass++;
      n_total++;
      if ({out_valid, out_illegal, out_rs1} !== {1'b1, 1'b1, 5'd1})
         $display("FAIL sat_stream_out: got valid=%b ill=%b rs1=%0d want 1 1 1", out_valid, out_illegal, out_rs1);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({out_valid, in_ready, illegal_count, out_rs1, out_rd, out_illegal} !== {1'b0, 1'b1, 8'd0, 5'd0, 5'd0, 1'b0})
         $display("FAIL midreset: got valid=%b ready=%b cnt=%0d rs1=%0d rd=%0d ill=%b want 0 1 0 0 0 0",
                  out_valid, in_ready, illegal_count, out_rs1, out_rd, out_illegal);
      else n_pass++;
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      n_total++;
      if ({out_valid, illegal_count} !== {1'b0, 8'd0})
         $display("FAIL post_reset: got valid=%b cnt=%0d want 0 0", out_valid, illegal_count);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
